// File: rtl/serial_sub_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_sub_fs.sv
// Combinational one-bit full subtractor: diff = a - b - bin, bw = borrow-out.
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bw
);

    assign diff = a ^ b ^ bin;
    assign bw   = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell iterated LSB-first over WIDTH SHIFT cycles.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bw,
    output logic             ovf
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e          state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [CntW-1:0]  cnt;
    logic             brw;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_bw;

    fs u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .diff (cell_d),
        .bw   (cell_bw)
    );

    assign diff = res;
    assign bw   = brw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            brw   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        ovf   <= 1'b0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end
                end
                StShift: begin
                    // Result fills from the top so the first (LSB) bit lands in bit 0.
                    res  <= {cell_d, res[WIDTH-1:1]};
                    brw  <= cell_bw;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LastCnt) begin
                        // cell_d is the result MSB on this final edge.
                        ovf   <= (a_msb != b_msb) && (cell_d != a_msb);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= StIdle;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 with directed vectors.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         bin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         ready;
    logic         busy;
    logic         done;
    logic         bw;
    logic         ovf;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bw    (bw),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bw;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_done = 0;
    int   n_exp_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_done: got done=1, required no done (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("bw", 32'(bw), 32'(e.bw));
                check("ovf", 32'(ovf), 32'(e.ov));
                check("latency", 32'(cyc - e.acc), 32'(W + 1));
                check("ready_in_done", 32'(ready), 32'd0);
            end
        end
    end

    // Caller sits at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                         input logic [W-1:0] ed, input logic ebw, input logic eov,
                         input bit expect_it);
        int t = 0;
        while (ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=%b, required 1", ready);
            return;
        end
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        if (expect_it) begin
            sb.push_back('{ed, ebw, eov, cyc});
            n_exp_done++;
        end
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || ready !== 1'b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got %0d pending results, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        @(negedge clk);
        // Start under reset must be ignored.
        a     = 8'h55;
        b     = 8'h11;
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bw", 32'(bw), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        drain();
        issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1);
        drain();
        issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        drain();
        issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1);
        drain();
        issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1);
        drain();

        // Start pulsed mid-SHIFT must be ignored.
        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a     = 8'h11;
        b     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignores_start", 32'(busy), 32'd1);
        drain();
        repeat (15) @(negedge clk);
        check("diff_held", 32'(diff), 32'h02);
        check("ready_after_ignore", 32'(ready), 32'd1);

        // Reset on the 4th SHIFT edge aborts without a done pulse.
        issue(8'h05, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b1);
        drain();

        // Start held 30 cycles: acceptances at offsets 0, 10, 20.
        begin
            int n0;
            n0    = cyc;
            a     = 8'h80;
            b     = 8'h01;
            bin   = 1'b0;
            start = 1'b1;
            for (int k = 0; k < 3; k++) begin
                sb.push_back('{8'h7F, 1'b0, 1'b1, n0 + 10 * k});
                n_exp_done++;
            end
            for (int k = 0; k < 30; k++) begin
                check("ready_held", 32'(ready), 32'((k % 10) == 0));
                @(negedge clk);
            end
            start = 1'b0;
        end
        drain();
        repeat (15) @(negedge clk);

        check("done_count", 32'(n_done), 32'(n_exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
